// File: rtl/systolic_array.sv
// ---------------------------------------------------------------------------
// systolic_array
//   Output-stationary systolic matrix multiplier, C = A x B.
//   A valid pulse latches both operand matrices. Operands are then fed with a
//   diagonal skew into an AROW x BCOL grid of multiply-accumulate PEs. A moves
//   east and B moves south, one register per hop. Each PE accumulates into its
//   own 2N-bit register, and those registers are exposed directly as the result.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   valid     : load strobe; latches a/b and restarts the computation
//   a         : matrix A, a[i][k], unsigned N-bit elements
//   b         : matrix B, b[k][j], unsigned N-bit elements
//   sys_array : accumulator grid, sys_array[i][j] = C[i][j] once complete
// ---------------------------------------------------------------------------
module systolic_array #(
    parameter int N    = 16,
    parameter int AROW = 4,
    parameter int ACOL = 4,
    parameter int BROW = 4,
    parameter int BCOL = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid,
    input  logic [AROW-1:0][ACOL-1:0][N-1:0]     a,
    input  logic [BROW-1:0][BCOL-1:0][N-1:0]     b,
    output logic [AROW-1:0][BCOL-1:0][2*N-1:0]   sys_array
);

    // The last feed step is t = LAST. Busy drops on the edge that consumes it.
    localparam int LAST = ACOL + AROW + BCOL - 2;
    localparam int TW   = $clog2(LAST + 2);
    localparam int KAW  = (ACOL > 1) ? $clog2(ACOL) : 1;
    localparam int KBW  = (BROW > 1) ? $clog2(BROW) : 1;
    // The forwarding registers exist only between neighbouring PEs.
    localparam int HC   = (BCOL > 1) ? BCOL - 1 : 1;
    localparam int VR   = (AROW > 1) ? AROW - 1 : 1;

    generate
        if (ACOL != BROW) begin : g_dim_chk
            $error("systolic_array: ACOL must equal BROW");
        end
    endgenerate

    logic [AROW-1:0][ACOL-1:0][N-1:0]   r_a;
    logic [BROW-1:0][BCOL-1:0][N-1:0]   r_b;
    logic [TW-1:0]                      r_t;
    logic                               r_busy;
    logic [AROW-1:0][BCOL-1:0][2*N-1:0] r_acc;
    logic [AROW-1:0][HC-1:0][N-1:0]     r_ah;
    logic [VR-1:0][BCOL-1:0][N-1:0]     r_bv;

    logic [AROW-1:0][N-1:0]             w_west;
    logic [BCOL-1:0][N-1:0]             w_north;
    logic [N-1:0]                       w_ain [AROW][BCOL];
    logic [N-1:0]                       w_bin [AROW][BCOL];

    // Skewed edge feed. Row i sees a[i][t-i] and column j sees b[t-j][j].
    // Outside the valid window the feed is zero, so the pipeline flushes with zeros.
    always_comb begin
        w_west  = '0;
        w_north = '0;
        for (int i = 0; i < AROW; i++) begin
            if (r_t >= TW'(i) && r_t < TW'(i + ACOL))
                w_west[i] = r_a[i][KAW'(r_t - TW'(i))];
        end
        for (int j = 0; j < BCOL; j++) begin
            if (r_t >= TW'(j) && r_t < TW'(j + BROW))
                w_north[j] = r_b[KBW'(r_t - TW'(j))][j];
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < AROW; gi++) begin : g_row
            for (gj = 0; gj < BCOL; gj++) begin : g_col
                if (gj == 0) begin : g_a_edge
                    assign w_ain[gi][gj] = w_west[gi];
                end else begin : g_a_fwd
                    assign w_ain[gi][gj] = r_ah[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign w_bin[gi][gj] = w_north[gj];
                end else begin : g_b_fwd
                    assign w_bin[gi][gj] = r_bv[gi-1][gj];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_t    <= '0;
            r_busy <= 1'b0;
            r_acc  <= '0;
            r_ah   <= '0;
            r_bv   <= '0;
        end else if (valid) begin
            // A load also aborts any computation that is still in flight.
            r_a    <= a;
            r_b    <= b;
            r_t    <= '0;
            r_busy <= 1'b1;
            r_acc  <= '0;
            r_ah   <= '0;
            r_bv   <= '0;
        end else if (r_busy) begin
            r_t <= r_t + TW'(1);
            if (r_t == TW'(LAST))
                r_busy <= 1'b0;
            for (int i = 0; i < AROW; i++) begin
                for (int j = 0; j < BCOL; j++) begin
                    // The full 2N-bit product is added with modulo 2^(2N) wrap.
                    r_acc[i][j] <= r_acc[i][j]
                                 + ((2*N)'(w_ain[i][j]) * (2*N)'(w_bin[i][j]));
                end
            end
            for (int i = 0; i < AROW; i++) begin
                for (int j = 0; j < BCOL - 1; j++) begin
                    r_ah[i][j] <= w_ain[i][j];
                end
            end
            for (int i = 0; i < AROW - 1; i++) begin
                for (int j = 0; j < BCOL; j++) begin
                    r_bv[i][j] <= w_bin[i][j];
                end
            end
        end
    end

    assign sys_array = r_acc;

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;

    localparam int N = 16;
    localparam int R = 4;
    localparam int K = 4;
    localparam int C = 4;

    typedef logic [R-1:0][K-1:0][N-1:0]   mat_t;
    typedef logic [R-1:0][C-1:0][2*N-1:0] res_t;
    typedef struct {
        string name;
        mat_t  a;
        mat_t  b;
        bit    use_model;
        res_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic valid;
    mat_t a;
    mat_t b;
    res_t sys_array;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    systolic_array #(.N(N), .AROW(R), .ACOL(K), .BROW(K), .BCOL(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .a         (a),
        .b         (b),
        .sys_array (sys_array)
    );

    function automatic res_t matmul(input mat_t x, input mat_t y);
        res_t r;
        r = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                for (int k = 0; k < K; k++)
                    r[i][j] = r[i][j] + (32'(x[i][k]) * 32'(y[k][j]));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, got, got, expv, expv);
        end
    endtask

    task automatic chk_mat(input string nm);
        res_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got [0][0]=%0d expected an entry", nm, sys_array[0][0]);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    chk($sformatf("%s[%0d][%0d]", nm, i, j), sys_array[i][j], e[i][j]);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < K; k++) begin
                a[i][k] = 16'($urandom);
                b[i][k] = 16'($urandom);
            end
    endtask

    // Returns at the falling edge just after the load edge E0.
    task automatic load(input mat_t xa, input mat_t xb);
        @(negedge clk);
        a     = xa;
        b     = xb;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    mat_t m_def_a, m_def_b, m_ident, m_ones, m_rnd_a, m_rnd_b;
    res_t r_zero, r_def, r_b_as_res;
    vec_t vecs[5];
    int   def_c[4][4] = '{'{250, 260, 270, 280}, '{618, 644, 670, 696},
                          '{986, 1028, 1070, 1112}, '{1354, 1412, 1470, 1528}};
    int   skew00[10]  = '{17, 59, 134, 250, 250, 250, 250, 250, 250, 250};
    int   skew33[10]  = '{0, 0, 0, 0, 0, 0, 260, 596, 1016, 1528};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < R; i++)
            for (int k = 0; k < K; k++) begin
                m_def_a[i][k] = 16'(4 * i + k + 1);
                m_def_b[i][k] = 16'(17 + 4 * i + k);
                m_ident[i][k] = (i == k) ? 16'd1 : 16'd0;
                m_ones[i][k]  = 16'hFFFF;
                m_rnd_a[i][k] = 16'($urandom);
                m_rnd_b[i][k] = 16'($urandom);
            end
        r_zero = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                r_def[i][j]      = 32'(def_c[i][j]);
                r_b_as_res[i][j] = 32'(m_def_b[i][j]);
            end

        vecs[0] = '{name: "default", a: m_def_a, b: m_def_b, use_model: 1'b0, exp: r_def};
        vecs[1] = '{name: "wrap",    a: m_ones,  b: m_ones,  use_model: 1'b0, exp: {16{32'hFFF80004}}};
        vecs[2] = '{name: "ident",   a: m_ident, b: m_def_b, use_model: 1'b0, exp: r_b_as_res};
        vecs[3] = '{name: "rand_ab", a: m_rnd_a, b: m_rnd_b, use_model: 1'b1, exp: r_zero};
        vecs[4] = '{name: "rand_b",  a: m_def_a, b: m_rnd_b, use_model: 1'b1, exp: r_zero};

        // Reset held with a live load request and nonzero operands.
        rst   = 1'b0;
        valid = 1'b1;
        a     = m_def_a;
        b     = m_def_b;
        after_edges(3);
        exp_q.push_back(r_zero);
        chk_mat("reset_hold");
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;

        // Table-driven products. The inputs are scrambled right after E0.
        for (int v = 0; v < 5; v++) begin
            res_t e;
            e = vecs[v].use_model ? matmul(vecs[v].a, vecs[v].b) : vecs[v].exp;
            exp_q.push_back(e);
            exp_q.push_back(e);
            load(vecs[v].a, vecs[v].b);
            after_edges(10);
            chk_mat({vecs[v].name, "_final"});
            after_edges(20);
            chk_mat({vecs[v].name, "_hold"});
        end

        // Skew timing of the first and last PE.
        load(m_def_a, m_def_b);
        for (int e = 0; e < 10; e++) begin
            after_edges(1);
            chk($sformatf("skew00_E%0d", e + 1), sys_array[0][0], 32'(skew00[e]));
            chk($sformatf("skew33_E%0d", e + 1), sys_array[3][3], 32'(skew33[e]));
        end

        // Back-to-back: a second load at E3 aborts the first computation.
        load(m_def_a, m_def_b);
        after_edges(2);
        exp_q.push_back(r_b_as_res);
        exp_q.push_back(r_b_as_res);
        load(m_ident, m_def_b);
        after_edges(10);
        chk_mat("b2b_final");
        after_edges(20);
        chk_mat("b2b_hold");

        // valid held high: every edge reloads, so the grid stays cleared.
        @(negedge clk);
        a     = m_def_a;
        b     = m_def_b;
        valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("held_clear00", sys_array[0][0], 32'd0);
        end
        @(negedge clk);
        valid = 1'b0;
        scramble_inputs();
        exp_q.push_back(matmul(m_def_a, m_def_b));
        after_edges(10);
        chk_mat("held_final");

        // Reset mid-run clears immediately and discards the computation.
        load(m_def_a, m_def_b);
        after_edges(5);
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(r_zero);
        chk_mat("async_rst");
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(r_zero);
        after_edges(8);
        chk_mat("rst_discard");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
# systolic_array

Output-stationary systolic matrix multiplier. It computes C = A × B for an AROW×ACOL matrix A and a BROW×BCOL matrix B of unsigned N-bit elements. A single-cycle `valid` pulse captures both matrices, which are then streamed with a diagonal skew through an AROW×BCOL grid of multiply-accumulate processing elements (PEs). It is the core MAC engine of the FPGA neural-network datapath, and the accumulator grid is exposed directly as the result.

## Interface
- `N`, default 16: element width in bits.
- `AROW`, default 4: rows of A, and rows of the PE grid.
- `ACOL`, default 4: columns of A. Must equal `BROW`; an elaboration-time error is raised otherwise.
- `BROW`, default 4: rows of B.
- `BCOL`, default 4: columns of B, and columns of the PE grid.
- One clock; reset is asynchronous and active-low.
- `clk`, input, 1 bit: rising-edge clock.
- `rst`, input, 1 bit: asynchronous active-low reset. 0 resets the block.
- `valid`, input, 1 bit: load strobe, sampled on the rising edge of `clk`.
- `a`, input, `[AROW-1:0][ACOL-1:0][N-1:0]`: matrix A. `a[i][k]` is row i, column k, unsigned.
- `b`, input, `[BROW-1:0][BCOL-1:0][N-1:0]`: matrix B. `b[k][j]` is row k, column j, unsigned.
- `sys_array`, output, `[AROW-1:0][BCOL-1:0][2*N-1:0]`: `sys_array[i][j]` is the registered accumulator of PE(i,j).
- There are no other ports.

## Operation
- **Load.** On a rising edge with `rst`=1 and `valid`=1 (edge E0):
  - latch `a` and `b` into internal operand buffers;
  - clear every accumulator and every inter-PE pipeline register to 0;
  - reset the feed counter t to 0 and set the block busy.
- **Feed.** On each later edge while busy, the counter t increments.
  - West edge of row i: receives `a[i][t-i]`, or 0 if t-i lies outside 0..ACOL-1.
  - North edge of column j: receives `b[t-j][j]`, or 0 if t-j lies outside 0..BROW-1.
- **PE(i,j), each edge:**
  - acc ← acc + a_in·b_in;
  - forward a_in east to PE(i,j+1) and b_in south to PE(i+1,j) through one register each.
- **Arithmetic.**
  - Product is N×N unsigned, giving a full 2N-bit result.
  - Accumulation is modulo 2^(2N): silent wrap, no saturation, no overflow flag.
- **Completion.** Busy clears after the last term reaches PE(AROW-1,BCOL-1). Accumulators then hold their values indefinitely until the next load or reset.
- **`valid` while busy.** The current computation is aborted and a fresh load (E0 behaviour) occurs on that edge.
- **`valid` held high for multiple cycles.** Each such edge is a new load. The result appears only after `valid` is deasserted.
- **Input changes after E0.** Changes to `a` or `b` have no effect; only the latched copies are used.

## Timing
- **Reset.** `rst`=0 asynchronously:
  - clears every `sys_array` element to 0;
  - clears all pipeline registers, operand buffers, counter and busy.
  - Deassertion takes effect at the next edge.
  - Reset mid-computation discards the computation.
- **Term arrival.** Term k of C[i][j] (a[i][k]·b[k][j]) is added at edge E(1+k+i+j).
- **Latency.**
  - C[i][j] is final after edge E(ACOL+i+j).
  - The full result is valid after edge E(ACOL+AROW+BCOL-2): 10 cycles for 4/4/4.
- **Visibility.** `sys_array` is registered and shows partial sums during the computation.
- **Busy timeout.** Busy drops at edge E(ACOL+AROW+BCOL-1). No further accumulation happens after that edge.

## Test plan
- **Reset.** Hold `rst`=0 with nonzero `a`/`b` and `valid`=1 → all 16 `sys_array` entries are 0. Pulse `rst`=0 mid-run → all entries 0 immediately, without waiting for a clock edge.
- **Default 4×4 product.** a rows = {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; b rows = {17..20}, {21..24}, {25..28}, {29..32}; one-cycle `valid` pulse. Required result after E10 and stable 20 cycles later:
  - row 0: 250, 260, 270, 280;
  - row 1: 618, 644, 670, 696;
  - row 2: 986, 1028, 1070, 1112;
  - row 3: 1354, 1412, 1470, 1528.
- **Skew timing, same stimulus.**
  - `sys_array[0][0]`: 17 after E1, 59 after E2, 250 after E4.
  - `sys_array[3][3]`: 0 through E6, 1528 after E10.
- **Wrap.** All a and b elements = 16'hFFFF → every entry = 32'hFFF80004 (4·0xFFFE0001 mod 2^32).
- **Back-to-back load.** Pulse `valid` with the default matrices, then pulse `valid` at E3 with a = identity and b = the default b → final result equals b (entry [i][j] = b[i][j]), with no residue from the first load.
- **Input independence.** Change `a`/`b` to random values on the cycle after E0 → result still equals the product of the latched matrices.
